// File: rtl/display_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB100 = 2'd1,
        SUB10  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned BCD_W    = 4;
    localparam logic [7:0]  DIV_HUND = 8'd100;
    localparam logic [7:0]  DIV_TEN  = 8'd10;

endpackage

// File: rtl/bcd_convert_scheduler_if.sv
// Request/result bundle between score sources, the converter and the HEX drivers.
interface bcd_convert_scheduler_if
    import display_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned VALUE_W = 8,
    parameter int unsigned ID_W    = 1
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*VALUE_W-1:0] req_value;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       busy;
    logic                       done;
    logic [ID_W-1:0]            done_id;
    logic [BCD_W-1:0]           hundreds;
    logic [BCD_W-1:0]           tens;
    logic [BCD_W-1:0]           ones;

    modport master (
        output req_valid, req_value,
        input  req_ready, busy, done, done_id, hundreds, tens, ones
    );

    modport slave (
        input  req_valid, req_value,
        output req_ready, busy, done, done_id, hundreds, tens, ones
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the source after the last winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Priority search starting at ptr_q+1, wrapping around.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // Winner becomes the lowest-priority source for the next round.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = grant_idx;
        end
    end

    // Pointer starts at the last source so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/bcd_convert_scheduler.sv
// Shares one repeated-subtraction binary-to-BCD converter between several sources.
module bcd_convert_scheduler
    import display_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned VALUE_W = 8,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic                    clk,
    input logic                    rst_n,
    bcd_convert_scheduler_if.slave bus
);
    state_e             state_q, state_d;
    logic [VALUE_W-1:0] work_q, work_d;
    logic [BCD_W-1:0]   h_q, h_d;
    logic [BCD_W-1:0]   t_q, t_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [BCD_W-1:0]   hundreds_q, hundreds_d;
    logic [BCD_W-1:0]   tens_q, tens_d;
    logic [BCD_W-1:0]   ones_q, ones_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_advance;
    logic [NUM_REQ-1:0] req_ready_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req_valid),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Conversion FSM: accept, subtract hundreds, subtract tens, publish.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        h_d         = h_q;
        t_d         = t_q;
        id_d        = id_q;
        hundreds_d  = hundreds_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        done_id_d   = done_id_q;
        arb_advance = 1'b0;
        req_ready_c = '0;

        case (state_q)
            IDLE: begin
                req_ready_c = arb_grant;
                if (|bus.req_valid) begin
                    arb_advance = 1'b1;
                    work_d      = bus.req_value[32'(arb_idx)*VALUE_W +: VALUE_W];
                    id_d        = arb_idx;
                    h_d         = '0;
                    t_d         = '0;
                    state_d     = SUB100;
                end
            end
            SUB100: begin
                if (work_q >= VALUE_W'(DIV_HUND)) begin
                    work_d = work_q - VALUE_W'(DIV_HUND);
                    h_d    = h_q + BCD_W'(1);
                end else begin
                    state_d = SUB10;
                end
            end
            SUB10: begin
                if (work_q >= VALUE_W'(DIV_TEN)) begin
                    work_d = work_q - VALUE_W'(DIV_TEN);
                    t_d    = t_q + BCD_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hundreds_d = h_q;
                tens_d     = t_q;
                ones_d     = work_q[BCD_W-1:0];
                done_id_d  = id_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_q == DONE);
        busy_d = (state_d != IDLE);
    end

    // State, working registers and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            h_q        <= '0;
            t_q        <= '0;
            id_q       <= '0;
            hundreds_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            done_id_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            h_q        <= h_d;
            t_q        <= t_d;
            id_q       <= id_d;
            hundreds_q <= hundreds_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            done_id_q  <= done_id_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.hundreds  = hundreds_q;
    assign bus.tens      = tens_q;
    assign bus.ones      = ones_q;
endmodule
